// File: rtl/berg_link_fifo.sv
// First-word-fall-through FIFO carrying WIDTH header channels across a board link.
// It reports occupancy and has a sticky overrun flag for sources that ignore ready.
module berg_link_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovr,
  input  logic                       ovr_clr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  // Handshake decodes come only from registered occupancy, so there is no
  // combinational path between the two sides of the link.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != CW'(0));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Storage holds no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A rejected write sets the flag; setting takes priority over clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (in_valid && !in_ready) begin
      ovr <= 1'b1;
    end else if (ovr_clr) begin
      ovr <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (count <= CW'(DEPTH));
      assert ((rd_ptr != wr_ptr) || (count == CW'(0)) || (count == CW'(DEPTH)));
    end
  end

endmodule

// File: tb/tb_berg_link_fifo.sv
// Directed bench for berg_link_fifo: queue model compared every cycle, plus
// hand-computed checks for latency, wrap, overrun and reset behaviour.
module tb_berg_link_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             ovr;
  logic             ovr_clr;

  int n_cmp;
  int n_err;

  berg_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue of words and an overrun bit.
  logic [WIDTH-1:0] mq[$];
  logic             movr;
  logic             m_full;
  logic             m_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      movr = 1'b0;
    end else begin
      m_full  = (mq.size() == DEPTH);
      m_empty = (mq.size() == 0);
      if (in_valid && m_full) movr = 1'b1;
      else if (ovr_clr)       movr = 1'b0;
      if (out_ready && !m_empty) void'(mq.pop_front());
      if (in_valid && !m_full)   mq.push_back(in_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, plus a log of words handed to the sink.
  logic [WIDTH-1:0] popped[$];
  logic             seen9;

  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_out_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("m_ovr", 32'(ovr), 32'(movr));
    if (!rst && out_valid && out_ready) popped.push_back(out_data);
    if (out_valid && out_data == 8'd9) seen9 = 1'b1;
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    ovr_clr   = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    seen9 = 1'b0;
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // 1: reset pulse mid-cycle forces outputs at once
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_count_pre", 32'(count), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_out_data", 32'(out_data), 32'd0);
    chk("t1_ovr", 32'(ovr), 32'd0);
    rst = 1'b0;
    tick();

    // 2: one-cycle latency, no bypass
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    #1;
    chk("t2_no_bypass", 32'(out_valid), 32'd0);
    tick();
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_data", 32'(out_data), 32'hA5);
    chk("t2_count", 32'(count), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("t2_count_pop", 32'(count), 32'd0);
    chk("t2_out_data_pop", 32'(out_data), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // 3: fill, then stream through the wrap point
    popped.delete();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_count_full", 32'(count), 32'd4);
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h05, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h06, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_pop_cnt", 32'(popped.size()), 32'd6);
    for (int i = 0; i < popped.size(); i++) chk("t3_order", 32'(popped[i]), 32'(i + 1));
    chk("t3_ovr", 32'(ovr), 32'd0);
    chk("t3_count_end", 32'(count), 32'd0);

    // 4: push while full with pop -> pop only, word lost, overrun
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'h09, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_count", 32'(count), 32'd3);
    chk("t4_ovr", 32'(ovr), 32'd1);
    chk("t4_head", 32'(out_data), 32'h21);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_no9", 32'(seen9), 32'd0);

    // 5: overrun clear, and set beating clear
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("t5_ovr_clr", 32'(ovr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'h07, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_ovr_set_wins", 32'(ovr), 32'd1);
    chk("t5_count", 32'(count), 32'd4);
    chk("t5_hold", 32'(out_data), 32'h40);

    // 6: reset with data queued, then restart from empty
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_count_pre", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    chk("t6_count_rst", 32'(count), 32'd0);
    chk("t6_out_valid_rst", 32'(out_valid), 32'd0);
    chk("t6_ovr_rst", 32'(ovr), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_out_valid", 32'(out_valid), 32'd1);
    chk("t6_out_data", 32'(out_data), 32'h3C);
    chk("t6_count", 32'(count), 32'd1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
